// File: rtl/asic_pkg.sv
// Shared definitions for the asic_seq program sequencer: opcode values,
// instruction field positions, FSM state encoding and small decode helpers.
package asic_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_WRITE = 4'h5;
  localparam logic [3:0] OP_READ  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int CH_MSB  = 9;
  localparam int CH_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_RWAIT  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  function automatic logic [3:0] get_op(input logic [15:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [1:0] get_ch(input logic [15:0] w);
    return w[CH_MSB:CH_LSB];
  endfunction

  function automatic logic [7:0] get_imm(input logic [15:0] w);
    return w[IMM_MSB:IMM_LSB];
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_WRITE) || (op == OP_READ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/asic_rom.sv
// Program store for asic_seq: a word-wide memory with a registered read
// port (data appears the cycle after ena) and a write port used to load
// the program before execution starts.
module asic_rom #(
  parameter int D_WIDTH    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clka,
  input  logic                  ena,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [D_WIDTH-1:0]    dout,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0]    wr_data
);

  logic [D_WIDTH-1:0] mem [DEPTH];

  // Program load port and registered read port share the single clock.
  always_ff @(posedge clka) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (ena) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/asic_seq.sv
// asic_seq: fetches 16-bit instructions from a registered ROM and turns
// them into channel write/read transactions with a valid/ready request
// and a separate read-response strobe.
// Optional build macro ASIC_SEQ_TIMEOUT_EN adds a watchdog on the ISSUE
// and RWAIT waits; without it those waits are unbounded.
module asic_seq
  import asic_pkg::*;
#(
  parameter int D_WIDTH     = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rom_ena,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [D_WIDTH-1:0]    rom_data,
  output logic                  ch_valid,
  input  logic                  ch_ready,
  output logic [1:0]            ch_sel,
  output logic                  ch_wr,
  output logic [7:0]            ch_wdata,
  input  logic                  ch_rvalid,
  input  logic [7:0]            ch_rdata,
  output logic [7:0]            rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(DEPTH - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [7:0]            dreg [4];
  logic [3:0]            op;
  logic [1:0]            ch;
  logic [7:0]            imm;
  logic                  adv;
  logic                  unused_bits;

  // Fields are only meaningful in DECODE, when rom_data holds the fetched word.
  assign op          = get_op(rom_data[15:0]);
  assign ch          = get_ch(rom_data[15:0]);
  assign imm         = get_imm(rom_data[15:0]);
  assign unused_bits = ^rom_data;

  assign rom_ena  = (state == S_FETCH);
  assign rom_addr = pc;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_HALT);

`ifdef ASIC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] tcnt;
  logic          waiting;
  logic          tmo;

  assign waiting = ((state == S_ISSUE) && !ch_ready) || ((state == S_RWAIT) && !ch_rvalid);
  assign tmo     = waiting && (tcnt == CW'(TIMEOUT_CYC - 1));

  // Watchdog: counts consecutive stalled cycles, restarts whenever the wait ends.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (waiting) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // An instruction retires (pc moves on) after a load/illegal decode, a write
  // handshake, or the read response.
  always_comb begin
    adv = 1'b0;
    case (state)
      S_DECODE: adv = (op == OP_LOAD) || !is_legal(op);
      S_ISSUE:  adv = ch_ready && ch_wr;
      S_RWAIT:  adv = ch_rvalid;
      default:  adv = 1'b0;
    endcase
  end

  // Main sequencer; retiring the last ROM word without a halt is an error
  // and stops execution instead of wrapping pc back to 0.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      dreg     <= '{default: '0};
      rd_data  <= '0;
      ch_valid <= 1'b0;
      ch_sel   <= '0;
      ch_wr    <= 1'b0;
      ch_wdata <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            err   <= 1'b0;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (op == OP_LOAD) begin
            dreg[ch] <= imm;
          end else if ((op == OP_WRITE) || (op == OP_READ)) begin
            ch_valid <= 1'b1;
            ch_sel   <= ch;
            ch_wr    <= (op == OP_WRITE);
            ch_wdata <= ((op == OP_WRITE) && (ch != 2'd0)) ? dreg[ch] : 8'h00;
            state    <= S_ISSUE;
          end else if (op == OP_HALT) begin
            state <= S_HALT;
          end else begin
            err <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (ch_ready) begin
            ch_valid <= 1'b0;
            if (!ch_wr) begin
              state <= S_RWAIT;
            end
          end
`ifdef ASIC_SEQ_TIMEOUT_EN
          else if (tmo) begin
            err      <= 1'b1;
            ch_valid <= 1'b0;
            state    <= S_HALT;
          end
`endif
        end
        S_RWAIT: begin
          if (ch_rvalid) begin
            rd_data <= ch_rdata;
          end
`ifdef ASIC_SEQ_TIMEOUT_EN
          else if (tmo) begin
            err   <= 1'b1;
            state <= S_HALT;
          end
`endif
        end
        S_HALT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (adv) begin
        if (pc == LAST_PC) begin
          err   <= 1'b1;
          state <= S_HALT;
        end else begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: doc/asic_seq.md
ASIC_SEQ -- requirements
Module: asic_seq

Interface
REQ-001 Parameter D_WIDTH, default 16, SHALL be the ROM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL be the ROM address width.
REQ-003 Parameter DEPTH, default 256, SHALL be the number of program words.
REQ-004 Parameter TIMEOUT_CYC, default 255, SHALL be the handshake watchdog limit in cycles.
REQ-005 Ports, in order:
- clka  in  1: the one clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: one-cycle pulse that begins execution at address 0.
- rom_ena  out  1: ROM read enable.
- rom_addr  out  ADDR_WIDTH: ROM read address.
- rom_data  in  D_WIDTH: registered ROM output, valid the cycle after rom_ena.
- ch_valid  out  1: channel request valid.
- ch_ready  in  1: channel request accepted.
- ch_sel  out  2: target channel; 0 = broadcast.
- ch_wr  out  1: 1 = write, 0 = read.
- ch_wdata  out  8: write data.
- ch_rvalid  in  1: read response valid.
- ch_rdata  in  8: read response data.
- rd_data  out  8: last captured read data.
- busy  out  1: program executing.
- done  out  1: one-cycle pulse on halt.
- err  out  1: sticky error flag.

Function
REQ-006 Instruction fields SHALL be: op = [15:12], ch = [9:8], imm = [7:0]; bits [11:10] are ignored.
REQ-007 Opcode 0x3 (load) SHALL set data register dreg[ch] = imm and take no bus cycle.
REQ-008 Opcode 0x5 (write) SHALL issue ch_valid with ch_wr=1, ch_sel=ch, ch_wdata=dreg[ch]; ch=0 SHALL send 0x00.
REQ-009 Opcode 0x6 (read) SHALL issue ch_valid with ch_wr=0, ch_sel=ch, then capture ch_rdata into rd_data on the first ch_rvalid.
REQ-010 Opcode 0xF (halt) SHALL end execution: done=1 for one cycle, busy=0.
REQ-011 Any other opcode SHALL set err and continue with the next word.
REQ-012 States SHALL be IDLE, FETCH, DECODE, ISSUE, RWAIT, HALT.
- IDLE -> FETCH on start; pc := 0.
- FETCH: rom_ena=1, rom_addr=pc; -> DECODE.
- DECODE: load/illegal -> FETCH with pc+1; write/read -> ISSUE; halt -> HALT.
- ISSUE: hold ch_valid and all ch_* stable until ch_ready; on handshake, write -> FETCH with pc+1, read -> RWAIT.
- RWAIT: on ch_rvalid -> FETCH with pc+1.
- HALT -> IDLE.
REQ-013 Load and illegal instructions SHALL take exactly 2 cycles; a write with ch_ready already high SHALL take 3 cycles.
REQ-014 rom_ena SHALL be 0 outside FETCH.
REQ-015 If pc = DEPTH-1 advances without a halt, the block SHALL set err and go to HALT; pc SHALL NOT wrap.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 ch_rvalid arriving outside RWAIT SHALL be ignored.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 Asserting rst SHALL, asynchronously and at any point mid-program, force:
- state IDLE, pc=0;
- all dreg and rd_data to 0;
- rom_ena, rom_addr, ch_valid, ch_sel, ch_wr, ch_wdata, busy, done and err to 0.
REQ-020 err SHALL clear only on rst or on an accepted start.

Configuration
REQ-021 With ASIC_SEQ_TIMEOUT_EN defined, a counter SHALL run in ISSUE and in RWAIT; reaching TIMEOUT_CYC cycles SHALL set err, drop ch_valid and go to HALT.
REQ-022 Without ASIC_SEQ_TIMEOUT_EN, ISSUE and RWAIT SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-023 Opcode constants (OP_LOAD=3, OP_WRITE=5, OP_READ=6, OP_HALT=F), field positions and the state encoding SHALL live in shared package asic_pkg.
REQ-024 The design SHALL be a single module with no sub-modules; the bench SHALL instantiate asic_rom as the program source.

Verification
REQ-025 Default program (5000,310F,321A,5100,5200,...,6100,6200,F000), ch_ready=1, ch_rvalid one cycle after each read request:
- writes SHALL be ch0=00, ch1=0F, ch2=1A, ch1=26, ch2=05, ch1=03, ch2=11;
- then two reads, then done;
- err SHALL be 0.
REQ-026 ch_ready held low for 10 cycles on the first write -> ch_valid and ch_sel/ch_wdata held stable for all 10 cycles; exactly one handshake.
REQ-027 Word 0x7000 at address 0 -> err=1, execution continues to the next word.
REQ-028 rst asserted during RWAIT -> all outputs 0 immediately; the next start restarts at pc=0.
REQ-029 With ASIC_SEQ_TIMEOUT_EN and ch_rvalid never asserted -> err=1 and done pulse TIMEOUT_CYC cycles after the read handshake.
REQ-030 ROM all 0x3000 (no halt) -> err=1 and HALT after address DEPTH-1; rom_addr never returns to 0.
